ysyx_22050612_imem_resp: RTL and testbench
==========================================

Name: ysyx_22050612_imem_resp

Overview:
- Instruction-memory responder: the far end of the fetch interface driven by the IFU.
- Accepts one fetch request (64-bit pc) at a time.
- Reads a 32-bit instruction word from an internal word-addressed store, waits a programmable latency, then holds the response until the IFU accepts it.
- Side write port preloads the program image (bench / boot loader).

Parameters:
- BASE, 64'h0000_0000_8000_0000, byte address of word 0
- DEPTH, 1024, number of 32-bit words (power of two, >= 2)
- LAT, 2, cycles from request acceptance to rsp_valid (1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  IFU presents a fetch address
- req_ready  out  1  responder can accept a request this cycle
- req_addr  in  64  fetch byte address (pc)
- rsp_valid  out  1  response data valid
- rsp_ready  in  1  IFU accepts the response
- rsp_inst  out  32  instruction word
- rsp_err  out  1  address misaligned or outside [BASE, BASE+4*DEPTH)
- wr_en  in  1  preload write strobe
- wr_idx  in  log2(DEPTH)  word index for preload
- wr_data  in  32  preload word

Behaviour:
- Reset (async, active-high): state=IDLE, req_ready=1, rsp_valid=0, rsp_inst=0, rsp_err=0, latency counter=0. Storage contents are not reset.
- Reset asserted mid-operation: the in-flight request is discarded and no response is issued after reset release.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Handshake req_valid&req_ready:
    - compute idx=(req_addr-BASE)>>2 (64-bit subtract) and err=(req_addr[1:0]!=0) | (req_addr<BASE) | (req_addr>=BASE+4*DEPTH).
    - Capture data=err?32'h0:mem[idx] and err into response registers.
    - Load counter=LAT-1.
    - Go to WAIT, or directly to RESP when LAT==1.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; when it reaches 0, go to RESP.
  - Handshake-to-rsp_valid latency is exactly LAT cycles.
- RESP:
  - rsp_valid=1; rsp_inst/rsp_err stable until the handshake.
  - On rsp_valid&rsp_ready: rsp_valid=0 next cycle, go to IDLE.
  - No back-to-back overlap: a new request is accepted at earliest the cycle after the response handshake.
- req_valid while not ready: ignored; the IFU must hold req_addr stable until accepted.
- rsp_ready low: the response is held indefinitely with no timeout.
- Preload write (wr_en) is accepted in any state, including WAIT/RESP; it writes mem[wr_idx]=wr_data on the rising edge.
- Read-capture ordering: data is captured at request acceptance.
  - A write to the same index in the acceptance cycle is not visible (old data returned).
  - A write to that index during WAIT/RESP does not alter rsp_inst.
- Address wrap: req_addr near 2^64 must not alias into range; the range check uses full 64-bit compare, never truncated idx.
- Last valid word: BASE+4*DEPTH-4 is in range. BASE+4*DEPTH sets err.

Decomposition:
- Shared package ysyx_22050612_pkg:
  - IMEM_BASE default.
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - INST_W=32.
  - NOP constant 32'h0000_0013 for bench use.
- One sub-module, ysyx_22050612_imem_array: DEPTH x 32 storage with one synchronous write port and one combinational read port. The FSM, range check and latency counter stay in the top.

Test Plan:
- Preload mem[0]=32'h0000_0413, mem[1]=32'h0010_0073; LAT=2; request 0x8000_0000 at cycle 0 with rsp_ready=1 -> rsp_valid at cycle 2, rsp_inst=32'h0000_0413, rsp_err=0; req_ready low cycles 1-2, high at cycle 3.
- Request 0x8000_0006 -> rsp_err=1, rsp_inst=0 after LAT cycles. Request 0x7FFF_FFFC -> err. Request 0x8000_0FFC (DEPTH=1024) -> err=0. Request 0x8000_1000 -> err=1. Request 0xFFFF_FFFF_FFFF_FFFC -> err=1.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_inst stable, req_ready=0 throughout; assert rsp_ready -> rsp_valid=0 and req_ready=1 next cycle.
- Accept request for idx 1 and write mem[1]=32'hDEAD_BEEF in the same cycle -> response returns old 32'h0010_0073; a following read of idx 1 returns 32'hDEAD_BEEF.
- Assert rst during WAIT (between accept and rsp_valid) -> outputs return to reset values immediately (async); no rsp_valid after release; the next request completes normally.
- LAT=1 build: request -> rsp_valid on the next cycle. Issue 8 consecutive pc+4 requests with rsp_ready=1 -> 8 responses in order, each exactly 1 cycle after its acceptance.

Source files
------------

// File: rtl/ysyx_22050612_pkg.sv
// Shared definitions for the instruction-memory responder and its bench.
package ysyx_22050612_pkg;

    localparam logic [63:0] IMEM_BASE = 64'h0000_0000_8000_0000;
    localparam int          INST_W    = 32;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_t;

endpackage

// File: rtl/ysyx_22050612_imem_array.sv
// DEPTH x 32 instruction store: one synchronous write port, one combinational read port.
// A read and write to the same index in one cycle returns the old word.
module ysyx_22050612_imem_array
    import ysyx_22050612_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] widx,
    input  logic [INST_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] ridx,
    output logic [INST_W-1:0]        rdata
);

    logic [INST_W-1:0] mem [DEPTH];

    // Preload write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) mem[widx] <= wdata;
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/ysyx_22050612_imem_resp.sv
// Instruction-memory responder: one fetch in flight, fixed LAT-cycle latency,
// response held until the IFU takes it. Data and error are captured at accept.
module ysyx_22050612_imem_resp
    import ysyx_22050612_pkg::*;
#(
    parameter logic [63:0] BASE  = IMEM_BASE,
    parameter int          DEPTH = 1024,
    parameter int          LAT   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [63:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [INST_W-1:0]        rsp_inst,
    output logic                     rsp_err,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [INST_W-1:0]        wr_data
);

    localparam int          AW       = $clog2(DEPTH);
    // First byte address past the store; range check is a full 64-bit compare
    // so addresses near 2^64 cannot alias back into the window.
    localparam logic [63:0] LIMIT    = BASE + 64'(DEPTH) * 64'd4;
    localparam logic [3:0]  CNT_LOAD = 4'(LAT - 1);

    imem_state_t       state, state_nxt;
    logic [3:0]        cnt;
    logic [63:0]       off;
    logic [AW-1:0]     idx;
    logic              err_c;
    logic              acc;
    logic [INST_W-1:0] rdata;
    logic              unused_off;

    assign off        = req_addr - BASE;
    assign idx        = off[AW+1:2];
    assign unused_off = ^{off[63:AW+2], off[1:0]};
    assign err_c      = (req_addr[1:0] != 2'b00) | (req_addr < BASE) | (req_addr >= LIMIT);
    assign acc        = req_valid & req_ready;

    ysyx_22050612_imem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .widx  (wr_idx),
        .wdata (wr_data),
        .ridx  (idx),
        .rdata (rdata)
    );

    // State register; reset drops any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs decoded from the current state.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = (LAT == 1) ? RESP : WAIT;
            end
            WAIT: begin
                // cnt==1 means this is the last wait cycle; 0 is a safety exit.
                if (cnt <= 4'd1) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latency counter: loaded at accept, counts down through WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            cnt <= 4'd0;
        else if (acc)                       cnt <= CNT_LOAD;
        else if (state == WAIT && cnt != 0) cnt <= cnt - 4'd1;
    end

    // Response capture at accept; later preload writes cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_inst <= '0;
            rsp_err  <= 1'b0;
        end else if (acc) begin
            rsp_inst <= err_c ? '0 : rdata;
            rsp_err  <= err_c;
        end
    end

endmodule

// File: tb/tb_ysyx_22050612_imem_resp.sv
// Bench for the instruction-memory responder: a LAT=2 and a LAT=1 instance
// share the clock, reset and preload bus; sel picks which one is exercised.
module tb_ysyx_22050612_imem_resp;
    import ysyx_22050612_pkg::*;

    localparam logic [63:0] B = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [63:0] req_addr = '0;
    logic        rsp_ready = 1'b0;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_idx = '0;
    logic [31:0] wr_data = '0;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_inst;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_inst;

    logic        o_req_ready, o_rsp_valid, o_rsp_err;
    logic [31:0] o_rsp_inst;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat = 2;
    logic [31:0] mm [1024];

    always #5 clk = ~clk;

    ysyx_22050612_imem_resp #(.BASE(B), .DEPTH(1024), .LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel), .req_ready(a_req_ready), .req_addr(req_addr),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel),
        .rsp_inst(a_rsp_inst), .rsp_err(a_rsp_err),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
    );

    ysyx_22050612_imem_resp #(.BASE(B), .DEPTH(1024), .LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(b_req_ready), .req_addr(req_addr),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel),
        .rsp_inst(b_rsp_inst), .rsp_err(b_rsp_err),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
    );

    assign o_req_ready = sel ? b_req_ready : a_req_ready;
    assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign o_rsp_inst  = sel ? b_rsp_inst  : a_rsp_inst;
    assign o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: the window is [B, B+4096), word aligned; outside it the word reads 0.
    function automatic void model(input logic [63:0] a, output logic e, output logic [31:0] d);
        e = (a % 64'd4 != 0) || (a < B) || (a >= B + 64'd4096);
        d = e ? 32'h0 : mm[(a - B) / 64'd4];
    endfunction

    // One clock; any pending preload write lands in the model at the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (wr_en) begin
            mm[wr_idx] = wr_data;
            wr_en = 1'b0;
        end
    endtask

    // wmode: 0 none, 1 write the fetched word in the accept cycle,
    //        2 write it in the cycle after accept.
    task automatic fetch(input logic [63:0] addr, input int hold, input int wmode, input logic [31:0] wd);
        logic        e;
        logic [31:0] d;
        int          n;
        model(addr, e, d);
        chk("req_ready_idle", {63'd0, o_req_ready}, 64'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        if (wmode == 1) begin wr_en = 1'b1; wr_idx = addr[11:2]; wr_data = wd; end
        step();
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        if (wmode == 2) begin wr_en = 1'b1; wr_idx = addr[11:2]; wr_data = wd; end
        n = 1;
        while (o_rsp_valid !== 1'b1 && n < 20) begin
            chk("req_ready_wait", {63'd0, o_req_ready}, 64'd0);
            step();
            n++;
        end
        chk("latency", 64'(n), 64'(lat));
        chk("rsp_inst", {32'd0, o_rsp_inst}, {32'd0, d});
        chk("rsp_err", {63'd0, o_rsp_err}, {63'd0, e});
        for (int h = 0; h < hold; h++) begin
            chk("req_ready_hold", {63'd0, o_req_ready}, 64'd0);
            step();
            chk("rsp_valid_hold", {63'd0, o_rsp_valid}, 64'd1);
            chk("rsp_inst_hold", {32'd0, o_rsp_inst}, {32'd0, d});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_valid_after", {63'd0, o_rsp_valid}, 64'd0);
        chk("req_ready_after", {63'd0, o_req_ready}, 64'd1);
    endtask

    initial begin
        logic [63:0] a;
        int          kind;
        int          wm;

        // Reset values on both instances.
        #2;
        chk("rst_req_ready_a", {63'd0, a_req_ready}, 64'd1);
        chk("rst_rsp_valid_a", {63'd0, a_rsp_valid}, 64'd0);
        chk("rst_rsp_inst_a", {32'd0, a_rsp_inst}, 64'd0);
        chk("rst_rsp_err_a", {63'd0, a_rsp_err}, 64'd0);
        chk("rst_req_ready_b", {63'd0, b_req_ready}, 64'd1);
        chk("rst_rsp_valid_b", {63'd0, b_rsp_valid}, 64'd0);
        step();
        step();
        rst = 1'b0;

        // Preload the whole image.
        for (int i = 0; i < 1024; i++) begin
            wr_en   = 1'b1;
            wr_idx  = 10'(i);
            wr_data = (i == 0) ? 32'h0000_0413 :
                      (i == 1) ? 32'h0010_0073 :
                      (i == 2) ? NOP : $urandom;
            step();
        end

        // Directed fetches, LAT=2.
        fetch(B, 0, 0, 0);
        chk("first_word", {32'd0, mm[0]}, 64'h0000_0413);
        fetch(B + 64'd6, 0, 0, 0);
        fetch(64'h7FFF_FFFC, 0, 0, 0);
        fetch(64'h8000_0FFC, 0, 0, 0);
        fetch(64'h8000_1000, 0, 0, 0);
        fetch(64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
        fetch(B + 64'd4, 5, 0, 0);
        fetch(B + 64'd4, 0, 1, 32'hDEAD_BEEF);
        fetch(B + 64'd4, 0, 0, 0);
        fetch(B + 64'd8, 2, 2, 32'hCAFE_F00D);
        fetch(B + 64'd8, 0, 0, 0);

        // Reset while a fetch is waiting.
        req_valid = 1'b1;
        req_addr  = B + 64'd4;
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
        chk("midrst_req_ready", {63'd0, o_req_ready}, 64'd1);
        chk("midrst_rsp_inst", {32'd0, o_rsp_inst}, 64'd0);
        chk("midrst_rsp_err", {63'd0, o_rsp_err}, 64'd0);
        step();
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("postrst_no_rsp", {63'd0, o_rsp_valid}, 64'd0);
        end
        rsp_ready = 1'b0;
        fetch(B + 64'd12, 0, 0, 0);

        // Randomized fetches, LAT=2.
        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 4));
            wm   = 0;
            case (kind)
                0, 1, 2: begin
                    a  = B + 64'd4 * 64'($urandom_range(0, 1023));
                    wm = int'($urandom_range(0, 2));
                end
                3:       a = B + 64'($urandom_range(0, 127));
                default: a = {$urandom, $urandom};
            endcase
            fetch(a, int'($urandom_range(0, 3)), wm, $urandom);
        end

        // LAT=1 instance: back-to-back sequential fetches.
        sel = 1'b1;
        lat = 1;
        for (int i = 0; i < 8; i++) fetch(B + 64'd4 * 64'(i), 0, 0, 0);
        fetch(64'h8000_1000, 1, 2, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
